// File: rtl/rv_encode_comp_packer_if.sv
// Handshake bundle between an instruction producer and the RVC packer.
// Latency: none, wires only.
// Backpressure: o_ready / i_ready are carried as plain signals; modports fix the direction.
interface rv_encode_comp_packer_if #(
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic [31:0]      i_instruction;
    logic             o_ready;
    logic             i_flush;
    logic             o_valid;
    logic [31:0]      o_word;
    logic             i_ready;
    logic             o_flush_done;
    logic             o_illegal;
    logic [CNT_W-1:0] o_cnt_comp;
    logic [CNT_W-1:0] o_cnt_full;

    // Packer side
    modport slave (
        input  i_valid, i_instruction, i_flush, i_ready,
        output o_ready, o_valid, o_word, o_flush_done, o_illegal, o_cnt_comp, o_cnt_full
    );

    // Producer / consumer side
    modport master (
        output i_valid, i_instruction, i_flush, i_ready,
        input  o_ready, o_valid, o_word, o_flush_done, o_illegal, o_cnt_comp, o_cnt_full
    );
endinterface

// File: rtl/rv_encode_comp_packer.sv
// RV32I -> RVC re-encoder packing 16/32-bit forms into a little-endian 32-bit word stream.
// Latency: one cycle from input handshake to o_valid; a flush takes one extra cycle in FLUSH.
// Backpressure: single output register; o_ready drops while that register is held or a flush is pending.
module rv_encode_comp_packer #(
    parameter int ENABLE_COMP = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    rv_encode_comp_packer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    logic [15:0]      hold_q;
    logic             valid_q;
    logic [31:0]      word_q;
    logic             flush_done_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_comp_q;
    logic [CNT_W-1:0] cnt_full_q;

    logic [31:0]        ins;
    logic [4:0]         rd, rs1, rs2, shamt;
    logic [2:0]         f3;
    logic [6:0]         f7, opcode;
    logic               rd_c, rs1_c, rs2_c;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_j;
    logic               comp_ok;
    logic [15:0]        comp_hw;
    logic               legal, use_comp, in_fire;

    assign ins    = bus.i_instruction;
    assign opcode = ins[6:0];
    assign rd     = ins[11:7];
    assign f3     = ins[14:12];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];
    assign shamt  = ins[24:20];
    assign f7     = ins[31:25];
    // Compressed register fields can only name x8..x15
    assign rd_c   = (rd[4:3]  == 2'b01);
    assign rs1_c  = (rs1[4:3] == 2'b01);
    assign rs2_c  = (rs2[4:3] == 2'b01);
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    assign legal    = (ins[1:0] == 2'b11);
    assign use_comp = (ENABLE_COMP != 0) && comp_ok;
    assign in_fire  = bus.i_valid && bus.o_ready;

    assign bus.o_ready      = (state_q != ST_FLUSH) && (!valid_q || bus.i_ready);
    assign bus.o_valid      = valid_q;
    assign bus.o_word       = word_q;
    assign bus.o_flush_done = flush_done_q;
    assign bus.o_illegal    = illegal_q;
    assign bus.o_cnt_comp   = cnt_comp_q;
    assign bus.o_cnt_full   = cnt_full_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Find an exact RVC equivalent of the incoming instruction, first matching rule wins
    always_comb begin
        comp_ok = 1'b0;
        comp_hw = 16'h0000;
        case (opcode)
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 0) begin
                        comp_ok = 1'b1; comp_hw = 16'h0001;
                    end else if (rd == rs1 && rd != 5'd0 && imm_i != 0 && imm_i >= -32 && imm_i <= 31) begin
                        comp_ok = 1'b1; comp_hw = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                    end else if (rd == 5'd2 && rs1 == 5'd2 && imm_i != 0 && imm_i[3:0] == 4'd0 &&
                                 imm_i >= -512 && imm_i <= 496) begin
                        comp_ok = 1'b1;
                        comp_hw = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
                    end else if (rs1 == 5'd2 && rd_c && imm_i[1:0] == 2'd0 && imm_i >= 4 && imm_i <= 1020) begin
                        comp_ok = 1'b1;
                        comp_hw = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
                    end else if (rs1 == 5'd0 && rd != 5'd0 && imm_i >= -32 && imm_i <= 31) begin
                        comp_ok = 1'b1; comp_hw = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                    end
                end else if (f3 == 3'b001) begin
                    if (f7 == 7'd0 && rd == rs1 && rd != 5'd0 && shamt != 5'd0) begin
                        comp_ok = 1'b1; comp_hw = {3'b000, 1'b0, rd, shamt, 2'b10};
                    end
                end else if (f3 == 3'b101) begin
                    if ((f7 == 7'b0000000 || f7 == 7'b0100000) && rd == rs1 && rd_c && shamt != 5'd0) begin
                        comp_ok = 1'b1; comp_hw = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], shamt, 2'b01};
                    end
                end else if (f3 == 3'b111) begin
                    if (rd == rs1 && rd_c && imm_i >= -32 && imm_i <= 31) begin
                        comp_ok = 1'b1; comp_hw = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
                    end
                end
            end
            7'b0110111: begin
                if (rd != 5'd0 && rd != 5'd2 && ins[31:12] != 20'd0 && ins[31:17] == {15{ins[17]}}) begin
                    comp_ok = 1'b1; comp_hw = {3'b011, ins[17], rd, ins[16:12], 2'b01};
                end
            end
            7'b0110011: begin
                if (f3 == 3'b000 && f7 == 7'd0) begin
                    if (rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                        comp_ok = 1'b1; comp_hw = {4'b1001, rd, rs2, 2'b10};
                    end else if (rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
                        comp_ok = 1'b1; comp_hw = {4'b1000, rd, rs2, 2'b10};
                    end
                end else if (rd == rs1 && rd_c && rs2_c) begin
                    if (f3 == 3'b000 && f7 == 7'b0100000) begin
                        comp_ok = 1'b1; comp_hw = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
                    end else if (f7 == 7'd0 && f3 == 3'b100) begin
                        comp_ok = 1'b1; comp_hw = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
                    end else if (f7 == 7'd0 && f3 == 3'b110) begin
                        comp_ok = 1'b1; comp_hw = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
                    end else if (f7 == 7'd0 && f3 == 3'b111) begin
                        comp_ok = 1'b1; comp_hw = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
                    end
                end
            end
            7'b0000011: begin
                if (f3 == 3'b010 && imm_i[1:0] == 2'd0 && imm_i >= 0) begin
                    if (rs1_c && rd_c && imm_i <= 124) begin
                        comp_ok = 1'b1;
                        comp_hw = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                    end else if (rs1 == 5'd2 && rd != 5'd0 && imm_i <= 252) begin
                        comp_ok = 1'b1;
                        comp_hw = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
                    end
                end
            end
            7'b0100011: begin
                if (f3 == 3'b010 && imm_s[1:0] == 2'd0 && imm_s >= 0) begin
                    if (rs1_c && rs2_c && imm_s <= 124) begin
                        comp_ok = 1'b1;
                        comp_hw = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                    end else if (rs1 == 5'd2 && imm_s <= 252) begin
                        comp_ok = 1'b1;
                        comp_hw = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
                    end
                end
            end
            7'b1100011: begin
                if ((f3 == 3'b000 || f3 == 3'b001) && rs1_c && rs2 == 5'd0 &&
                    imm_b >= -256 && imm_b <= 254) begin
                    comp_ok = 1'b1;
                    comp_hw = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0],
                               imm_b[7:6], imm_b[2:1], imm_b[5], 2'b01};
                end
            end
            7'b1101111: begin
                if ((rd == 5'd0 || rd == 5'd1) && imm_j >= -2048 && imm_j <= 2046) begin
                    comp_ok = 1'b1;
                    comp_hw = {~rd[0], 2'b01, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6],
                               imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
                end
            end
            7'b1100111: begin
                if (f3 == 3'b000 && (rd == 5'd0 || rd == 5'd1) && rs1 != 5'd0 && imm_i == 0) begin
                    comp_ok = 1'b1; comp_hw = {3'b100, rd[0], rs1, 5'd0, 2'b10};
                end
            end
            7'b1110011: begin
                if (ins == 32'h0010_0073) begin
                    comp_ok = 1'b1; comp_hw = 16'h9002;
                end
            end
            default: ;
        endcase
    end

    // Packing FSM, output register, pulses and statistics counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_EMPTY;
            hold_q       <= 16'h0000;
            valid_q      <= 1'b0;
            word_q       <= 32'h0000_0000;
            flush_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            cnt_comp_q   <= '0;
            cnt_full_q   <= '0;
        end else begin
            flush_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            if (valid_q && bus.i_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                // FLUSH is only entered with a halfword held, so it always pads with c.nop
                ST_FLUSH: begin
                    if (!valid_q || bus.i_ready) begin
                        valid_q      <= 1'b1;
                        word_q       <= {16'h0001, hold_q};
                        flush_done_q <= 1'b1;
                        state_q      <= ST_EMPTY;
                    end
                end
                default: begin
                    if (in_fire) begin
                        if (!legal) begin
                            illegal_q <= 1'b1;
                        end else if (use_comp) begin
                            cnt_comp_q <= sat_inc(cnt_comp_q);
                            if (state_q == ST_HALF) begin
                                valid_q <= 1'b1;
                                word_q  <= {comp_hw, hold_q};
                                state_q <= ST_EMPTY;
                            end else begin
                                hold_q  <= comp_hw;
                                state_q <= ST_HALF;
                            end
                        end else begin
                            cnt_full_q <= sat_inc(cnt_full_q);
                            valid_q    <= 1'b1;
                            if (state_q == ST_HALF) begin
                                word_q <= {ins[15:0], hold_q};
                                hold_q <= ins[31:16];
                            end else begin
                                word_q <= ins;
                            end
                        end
                    end else if (bus.i_flush) begin
                        // Nothing held: acknowledge immediately without touching the output
                        if (state_q == ST_HALF) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            flush_done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
